// File: rtl/sc_backg_scheduler.sv
// rtl/sc_backg_scheduler.sv - background row-bank command scheduler (clear/scroll/load arbitration)
// Optional pause input enabled by defining SC_BACKGSCHED_PAUSE_EN.
module sc_backg_scheduler #(
  parameter int ROWS       = 8,
  parameter int ROW_ADDR_W = 3,
  parameter int TICK_DIV   = 25000000
) (
  input  logic                  SC_BACKGSCHED_CLOCK_50,
  input  logic                  SC_BACKGSCHED_RESET_InHigh,
  input  logic                  SC_BACKGSCHED_startButton_InLow,
  input  logic                  SC_BACKGSCHED_loadReq_InHigh,
`ifdef SC_BACKGSCHED_PAUSE_EN
  input  logic                  SC_BACKGSCHED_pauseButton_InLow,
`endif
  output logic                  SC_BACKGSCHED_clear_OutLow,
  output logic                  SC_BACKGSCHED_load_OutLow,
  output logic                  SC_BACKGSCHED_shift_OutLow,
  output logic [ROW_ADDR_W-1:0] SC_BACKGSCHED_rowSel_Out,
  output logic                  SC_BACKGSCHED_loadAck_OutHigh,
  output logic                  SC_BACKGSCHED_busy_OutHigh
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0]    PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [ROW_ADDR_W-1:0] ROW_LAST   = ROW_ADDR_W'(ROWS - 1);
  localparam logic [ROW_ADDR_W-1:0] ROW_ONE    = ROW_ADDR_W'(1);

  typedef enum logic [3:0] {
    RESET        = 4'd0,
    START        = 4'd1,
    WAIT_PRESS   = 4'd2,
    CLEAR        = 4'd3,
    WAIT_RELEASE = 4'd4,
    IDLE         = 4'd5,
    SCROLL       = 4'd6,
    SCROLL_CLR   = 4'd7,
    LOAD         = 4'd8
  } state_t;

  state_t                  state, nextState;
  logic [ROW_ADDR_W-1:0]   rowCnt, nextRowCnt;
  logic [PRESC_W-1:0]      prescaler;
  logic                    pending;
  logic                    clearPending;
  logic                    prescHeld;
  logic                    pauseActive;
  logic                    tick;

`ifdef SC_BACKGSCHED_PAUSE_EN
  assign pauseActive = ~SC_BACKGSCHED_pauseButton_InLow;
`else
  assign pauseActive = 1'b0;
`endif

  // Prescaler and pending flag sit at zero until the first start press
  assign prescHeld = (state == RESET) || (state == START) || (state == WAIT_PRESS);
  assign tick      = !prescHeld && !pauseActive && (prescaler == PRESC_LAST);

  always_ff @(posedge SC_BACKGSCHED_CLOCK_50 or posedge SC_BACKGSCHED_RESET_InHigh) begin
    if (SC_BACKGSCHED_RESET_InHigh) begin
      prescaler <= '0;
    end else if (prescHeld) begin
      prescaler <= '0;
    end else if (!pauseActive) begin
      prescaler <= tick ? '0 : prescaler + PRESC_W'(1);
    end
  end

  // A tick coinciding with the IDLE->SCROLL dispatch wins over the clear
  always_ff @(posedge SC_BACKGSCHED_CLOCK_50 or posedge SC_BACKGSCHED_RESET_InHigh) begin
    if (SC_BACKGSCHED_RESET_InHigh) begin
      pending <= 1'b0;
    end else if (prescHeld) begin
      pending <= 1'b0;
    end else if (tick) begin
      pending <= 1'b1;
    end else if (clearPending) begin
      pending <= 1'b0;
    end
  end

  always_ff @(posedge SC_BACKGSCHED_CLOCK_50 or posedge SC_BACKGSCHED_RESET_InHigh) begin
    if (SC_BACKGSCHED_RESET_InHigh) begin
      state  <= RESET;
      rowCnt <= '0;
    end else begin
      state  <= nextState;
      rowCnt <= nextRowCnt;
    end
  end

  always_comb begin
    nextState    = state;
    nextRowCnt   = rowCnt;
    clearPending = 1'b0;
    case (state)
      RESET:      nextState = START;
      START:      nextState = WAIT_PRESS;
      WAIT_PRESS: begin
        nextRowCnt = '0;
        if (!SC_BACKGSCHED_startButton_InLow) nextState = CLEAR;
      end
      CLEAR: begin
        if (rowCnt == ROW_LAST) begin
          nextState  = WAIT_RELEASE;
          nextRowCnt = '0;
        end else begin
          nextRowCnt = rowCnt + ROW_ONE;
        end
      end
      WAIT_RELEASE: begin
        if (SC_BACKGSCHED_startButton_InLow) nextState = IDLE;
      end
      IDLE: begin
        nextRowCnt = '0;
        if (!SC_BACKGSCHED_startButton_InLow) begin
          nextState = CLEAR;
        end else if (pending && !pauseActive) begin
          nextState    = SCROLL;
          nextRowCnt   = ROW_LAST;
          clearPending = 1'b1;
        end else if (SC_BACKGSCHED_loadReq_InHigh) begin
          nextState = LOAD;
        end
      end
      // Destination-first walk: row r is overwritten only after it was copied to r+1
      SCROLL: begin
        if (rowCnt == ROW_ONE) begin
          nextState  = SCROLL_CLR;
          nextRowCnt = '0;
        end else begin
          nextRowCnt = rowCnt - ROW_ONE;
        end
      end
      SCROLL_CLR: nextState = IDLE;
      LOAD:       nextState = IDLE;
      default: begin
        nextState  = IDLE;
        nextRowCnt = '0;
      end
    endcase
  end

  always_comb begin
    SC_BACKGSCHED_clear_OutLow    = 1'b1;
    SC_BACKGSCHED_load_OutLow     = 1'b1;
    SC_BACKGSCHED_shift_OutLow    = 1'b1;
    SC_BACKGSCHED_rowSel_Out      = '0;
    SC_BACKGSCHED_loadAck_OutHigh = 1'b0;
    SC_BACKGSCHED_busy_OutHigh    = 1'b0;
    case (state)
      CLEAR: begin
        SC_BACKGSCHED_clear_OutLow = 1'b0;
        SC_BACKGSCHED_rowSel_Out   = rowCnt;
        SC_BACKGSCHED_busy_OutHigh = 1'b1;
      end
      SCROLL: begin
        SC_BACKGSCHED_shift_OutLow = 1'b0;
        SC_BACKGSCHED_rowSel_Out   = rowCnt;
        SC_BACKGSCHED_busy_OutHigh = 1'b1;
      end
      SCROLL_CLR: begin
        SC_BACKGSCHED_clear_OutLow = 1'b0;
        SC_BACKGSCHED_busy_OutHigh = 1'b1;
      end
      LOAD: begin
        SC_BACKGSCHED_load_OutLow     = 1'b0;
        SC_BACKGSCHED_loadAck_OutHigh = 1'b1;
        SC_BACKGSCHED_busy_OutHigh    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sc_backg_scheduler.sv
// tb/tb_sc_backg_scheduler.sv - directed self-checking bench for sc_backg_scheduler
// Exercises the pause input when SC_BACKGSCHED_PAUSE_EN is defined.
module tb_sc_backg_scheduler;

  localparam int ROWS       = 4;
  localparam int ROW_ADDR_W = 2;
  localparam int TICK_DIV   = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  startN;
  logic                  loadReq;
`ifdef SC_BACKGSCHED_PAUSE_EN
  logic                  pauseN;
`endif
  logic                  clearN, loadN, shiftN, loadAck, busy;
  logic [ROW_ADDR_W-1:0] rowSel;

  int nAsserts = 0;
  int nFails   = 0;

  always #5 clk = ~clk;

  sc_backg_scheduler #(.ROWS(ROWS), .ROW_ADDR_W(ROW_ADDR_W), .TICK_DIV(TICK_DIV)) dut (
    .SC_BACKGSCHED_CLOCK_50          (clk),
    .SC_BACKGSCHED_RESET_InHigh      (rst),
    .SC_BACKGSCHED_startButton_InLow (startN),
    .SC_BACKGSCHED_loadReq_InHigh    (loadReq),
`ifdef SC_BACKGSCHED_PAUSE_EN
    .SC_BACKGSCHED_pauseButton_InLow (pauseN),
`endif
    .SC_BACKGSCHED_clear_OutLow      (clearN),
    .SC_BACKGSCHED_load_OutLow       (loadN),
    .SC_BACKGSCHED_shift_OutLow      (shiftN),
    .SC_BACKGSCHED_rowSel_Out        (rowSel),
    .SC_BACKGSCHED_loadAck_OutHigh   (loadAck),
    .SC_BACKGSCHED_busy_OutHigh      (busy)
  );

  // Observed vector: {clear, load, shift, rowSel, loadAck, busy}
  wire [6:0] obs = {clearN, loadN, shiftN, rowSel, loadAck, busy};

  localparam logic [6:0] V_IDLE = 7'b111_00_0_0;
  localparam logic [6:0] V_LOAD = 7'b101_00_1_1;

  function automatic logic [6:0] vClr(int r);
    logic [1:0] rs;
    rs = r[1:0];
    return {3'b011, rs, 2'b01};
  endfunction

  function automatic logic [6:0] vShf(int r);
    logic [1:0] rs;
    rs = r[1:0];
    return {3'b110, rs, 2'b01};
  endfunction

  task automatic chk(input string tag, input int idx, input logic [6:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s[%0d] observed=%b expected=%b", tag, idx, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idleRun(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk(tag, i, V_IDLE);
    end
  endtask

  task automatic scrollSeq(input string tag);
    for (int r = ROWS - 1; r >= 1; r--) begin
      step();
      chk(tag, r, vShf(r));
    end
    step();
    chk(tag, 0, vClr(0));
  endtask

  task automatic clearSeq(input string tag);
    for (int r = 0; r < ROWS; r++) begin
      step();
      chk(tag, r, vClr(r));
    end
  endtask

  initial begin
    rst = 1'b1;
    startN = 1'b1;
    loadReq = 1'b0;
`ifdef SC_BACKGSCHED_PAUSE_EN
    pauseN = 1'b1;
`endif
    #2;
    chk("reset", 0, V_IDLE);
    step();
    chk("reset", 1, V_IDLE);
    rst = 1'b0;
    // RESET -> START -> WAIT_PRESS, then one more idle cycle with start released
    idleRun("boot", 3);

    // start held low 6 cycles: 4 clear cycles, then hold in WAIT_RELEASE
    startN = 1'b0;
    clearSeq("clear1");
    idleRun("waitRel", 2);
    startN = 1'b1;

    // periodic scroll: pending visible after cycle 17, scroll cycles 18..21 and 34..37
    idleRun("idle1", 11);
    scrollSeq("scroll1");
    idleRun("idle2", 12);
    scrollSeq("scroll2");
    idleRun("idle3", 1);

    // held loadReq is granted every other cycle
    loadReq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("loadHeld", 2 * i, V_LOAD);
      step();
      chk("loadHeld", 2 * i + 1, V_IDLE);
    end
    loadReq = 1'b0;
    idleRun("idle4", 5);

    // loadReq rises as pending becomes visible: scroll first, ack on 6th cycle
    loadReq = 1'b1;
    scrollSeq("scrollFirst");
    step();
    chk("loadAfterScroll", 0, V_IDLE);
    step();
    chk("loadAfterScroll", 1, V_LOAD);
    loadReq = 1'b0;
    idleRun("idle5", 10);

    // reset during 2nd scroll cycle
    step();
    chk("scrollRst", 3, vShf(3));
    step();
    chk("scrollRst", 2, vShf(2));
    #2;
    rst = 1'b1;
    #1;
    chk("asyncRst", 0, V_IDLE);
    step();
    chk("asyncRst", 1, V_IDLE);
    rst = 1'b0;
    loadReq = 1'b1;
    idleRun("noStrobe", 22);
    loadReq = 1'b0;

    // new start press required
    startN = 1'b0;
    clearSeq("clear2");
    startN = 1'b1;
    idleRun("idle6", 13);
    scrollSeq("scroll3");
    idleRun("idle7", 1);

`ifdef SC_BACKGSCHED_PAUSE_EN
    // prescaler frozen at 5 for 40 cycles; loads still serviced
    pauseN = 1'b0;
    for (int i = 0; i < 10; i++) begin
      loadReq = 1'b1;
      step();
      chk("pauseLoad", i, V_LOAD);
      loadReq = 1'b0;
      idleRun("pauseIdle", 3);
    end
    pauseN = 1'b1;
    // resumes from 5: tick after 11 cycles, scroll dispatched the cycle after
    idleRun("resume", 11);
    scrollSeq("scrollPause");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule

// File: doc/sc_backg_scheduler.md
Name: sc_backg_scheduler

Overview:
- Controller that sequences and shares the background row-register bank (ROWS rows, each with clear/load/shift-down strobes, active-low).
- Arbitrates between three requesters: start-button restart (full clear), an internal periodic scroll tick, and an external row-0 load request from game logic.
- Issues one bank command per cycle with a row select.
- Sits between the button/game logic and the background register bank.

Parameters:
- ROWS, 8, number of background rows; must be at least 2.
- ROW_ADDR_W, 3, width of the row select; must satisfy 2^ROW_ADDR_W >= ROWS.
- TICK_DIV, 25000000, scroll period in clocks; must be at least 2.

Ports:
- SC_BACKGSCHED_CLOCK_50  in  1  system clock, rising edge.
- SC_BACKGSCHED_RESET_InHigh  in  1  asynchronous active-high reset.
- SC_BACKGSCHED_startButton_InLow  in  1  start/restart button, active low, already synchronized.
- SC_BACKGSCHED_loadReq_InHigh  in  1  level request to load new data into row 0; held until ack.
- SC_BACKGSCHED_clear_OutLow  out  1  clear row rowSel.
- SC_BACKGSCHED_load_OutLow  out  1  load row rowSel (always row 0) from the game-logic data bus.
- SC_BACKGSCHED_shift_OutLow  out  1  copy row rowSel-1 into row rowSel.
- SC_BACKGSCHED_rowSel_Out  out  ROW_ADDR_W  target row.
- SC_BACKGSCHED_loadAck_OutHigh  out  1  one-cycle grant pulse for loadReq.
- SC_BACKGSCHED_busy_OutHigh  out  1  a bank command sequence is in progress.

Behaviour:
- Interface
  - One clock; reset is asynchronous and active-high.
  - Reset forces state RESET, row counter 0, prescaler 0, scroll-pending 0.
- Outputs
  - Moore outputs decoded from state and row counter; rowSel equals the row counter.
  - Idle/reset values: clear=1, load=1, shift=1, rowSel=0, loadAck=0, busy=0.
  - At most one strobe is low in any cycle.
- States
  - RESET -> START unconditionally.
  - START -> WAIT_PRESS unconditionally.
  - WAIT_PRESS: prescaler held at 0, pending held at 0. If start==0 -> CLEAR with counter=0.
  - CLEAR: clear=0, busy=1. Counter increments each cycle. In the cycle with counter==ROWS-1 -> WAIT_RELEASE. Lasts exactly ROWS cycles with rowSel 0..ROWS-1.
  - WAIT_RELEASE: outputs idle. start==1 -> IDLE (prevents retrigger while the button is held).
  - IDLE: fixed priority, evaluated each cycle.
    - start==0 -> CLEAR, counter=0.
    - else pending==1 -> SCROLL, counter=ROWS-1.
    - else loadReq==1 -> LOAD.
    - else stay.
  - SCROLL: shift=0, busy=1. Counter decrements; when counter==1 -> SCROLL_CLR with counter=0. rowSel sequence is ROWS-1 down to 1, destination-first, so data is never overwritten before it is copied.
  - SCROLL_CLR: clear=0, rowSel=0, busy=1, one cycle -> IDLE.
  - LOAD: load=0, rowSel=0, loadAck=1, busy=1, one cycle -> IDLE.
- Prescaler and pending flag
  - Prescaler runs in every state except RESET, START and WAIT_PRESS.
  - Counts 0..TICK_DIV-1 and wraps to 0; at terminal count it sets pending.
  - Pending is cleared on the IDLE->SCROLL transition. If a tick fires in that same cycle, set wins and pending stays 1.
  - A tick arriving while pending==1 is absorbed; there is no queueing beyond one.
- Sequences are never interrupted
  - Start presses, loadReq and ticks are sampled only in IDLE; pending records ticks meanwhile.
- Latency
  - loadReq sampled in IDLE with pending==0 -> loadAck high on the next cycle.
  - A continuously held loadReq is granted every 2 cycles (LOAD, IDLE, LOAD, ...).
- Reset mid-operation: all strobes deassert immediately (asynchronous); the FSM restarts at RESET and requires a new start press.
- Unreachable state encodings -> IDLE with idle outputs.

Optional Feature:
- Macro: SC_BACKGSCHED_PAUSE_EN.
- Defined:
  - Adds input SC_BACKGSCHED_pauseButton_InLow (1 bit, active low).
  - While it is low, the prescaler is frozen (holds its value) and IDLE does not dispatch SCROLL. Pending is retained.
  - LOAD and start-restart are still serviced during pause.
  - Releasing pause resumes counting from the frozen value.
- Undefined: the port does not exist and scrolling is never inhibited.

Test Plan (ROWS=4, ROW_ADDR_W=2, TICK_DIV=16):
- Reset, then start low for 6 cycles -> clear low 4 cycles, rowSel 0,1,2,3, busy=1; FSM then holds in WAIT_RELEASE until start=1; no second clear sequence.
- Idle after start with loadReq=0 -> 16 clocks after leaving WAIT_PRESS, shift low 3 cycles with rowSel 3,2,1, then clear low 1 cycle with rowSel 0; busy high for 4 cycles; this repeats every 16 clocks.
- loadReq=1 held in IDLE with pending=0 -> load low, rowSel 0, loadAck pulse the next cycle; while still held, ack repeats every 2 cycles.
- loadReq rises in the same cycle pending is set -> scroll sequence (4 cycles) runs first; loadAck arrives in the 6th cycle after sampling.
- Reset asserted during the 2nd SCROLL cycle -> shift goes high immediately, outputs idle, rowSel 0; no strobes occur until a new start press.
- With SC_BACKGSCHED_PAUSE_EN, pause low for 40 cycles while loadReq pulses -> no shift strobes and loads are acked; after pause release, scroll fires once the remaining prescaler count elapses.
